// File: rtl/sram_march_bist.sv
// March C- BIST controller for a single-port SRAM macro BIST port.
// Issues 10*N back-to-back accesses, checks reads two cycles later and reports the first failure.
module sram_march_bist #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          pass_o,
  output logic [AW-1:0] fail_addr_o,
  output logic [2:0]    fail_elem_o,
  output logic [DW-1:0] fail_syn_o,
  output logic [15:0]   fail_cnt_o,
  output logic          bist_en_o,
  output logic          bist_men_o,
  output logic          bist_wen_o,
  output logic          bist_ren_o,
  output logic [AW-1:0] bist_addr_o,
  output logic [DW-1:0] bist_din_o,
  output logic [DW-1:0] bist_bm_o,
  input  logic [DW-1:0] dout_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  // ph selects the read (0) or write (1) half of the two-access elements E1..E4
  function automatic logic elem_is_read(input logic [2:0] elem, input logic ph);
    case (elem)
      3'd0:    elem_is_read = 1'b0;
      3'd5:    elem_is_read = 1'b1;
      default: elem_is_read = ~ph;
    endcase
  endfunction

  function automatic logic elem_bit(input logic [2:0] elem, input logic ph);
    case (elem)
      3'd1, 3'd3: elem_bit = ph;
      3'd2, 3'd4: elem_bit = ~ph;
      default:    elem_bit = 1'b0;
    endcase
  endfunction

  state_t        state_r;
  logic [2:0]    elem_r;
  logic [AW-1:0] addr_r;
  logic          ph_r;

  logic          s1_vld_r, s2_vld_r;
  logic [DW-1:0] s1_exp_r, s2_exp_r;
  logic [AW-1:0] s1_addr_r, s2_addr_r;
  logic [2:0]    s1_elem_r, s2_elem_r;

  logic          cur_desc_s, elem_end_s, last_s, two_op_s;
  logic [2:0]    nx_elem_s, ld_elem_s;
  logic [AW-1:0] nx_addr_s, ld_addr_s;
  logic          nx_ph_s, ld_ph_s, start_acc_s, load_s, ld_rd_s;
  logic [DW-1:0] ld_pat_s, syn_s;
  logic          mis_s;
  logic [15:0]   cnt_nx_s;

  // Next access pointer in March order and the access to load this edge
  always_comb begin
    cur_desc_s = (elem_r == 3'd3) || (elem_r == 3'd4);
    two_op_s   = (elem_r != 3'd0) && (elem_r != 3'd5);
    elem_end_s = cur_desc_s ? (addr_r == {AW{1'b0}}) : (addr_r == ADDR_MAX);
    last_s     = (elem_r == 3'd5) && elem_end_s;
    nx_elem_s  = elem_r;
    nx_addr_s  = addr_r;
    nx_ph_s    = 1'b0;
    if (two_op_s && !ph_r) begin
      nx_ph_s = 1'b1;
    end else if (elem_end_s) begin
      nx_elem_s = elem_r + 3'd1;
      nx_addr_s = ((nx_elem_s == 3'd3) || (nx_elem_s == 3'd4)) ? ADDR_MAX : {AW{1'b0}};
    end else if (cur_desc_s) begin
      nx_addr_s = addr_r - ADDR_ONE;
    end else begin
      nx_addr_s = addr_r + ADDR_ONE;
    end
    start_acc_s = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && start_i;
    load_s      = start_acc_s || ((state_r == ST_RUN) && !last_s);
    ld_elem_s   = start_acc_s ? 3'd0 : nx_elem_s;
    ld_addr_s   = start_acc_s ? {AW{1'b0}} : nx_addr_s;
    ld_ph_s     = start_acc_s ? 1'b0 : nx_ph_s;
    ld_rd_s     = elem_is_read(ld_elem_s, ld_ph_s);
    ld_pat_s    = {DW{elem_bit(ld_elem_s, ld_ph_s)}};
  end

  // Read-data compare against the expectation leaving the second pipeline stage
  always_comb begin
    syn_s    = dout_i ^ s2_exp_r;
    mis_s    = s2_vld_r && (syn_s != {DW{1'b0}});
    cnt_nx_s = (mis_s && (fail_cnt_o != 16'hFFFF)) ? (fail_cnt_o + 16'd1) : fail_cnt_o;
  end

  // Sequencer, access drive, read pipeline and result capture
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      elem_r      <= 3'd0;
      addr_r      <= {AW{1'b0}};
      ph_r        <= 1'b0;
      s1_vld_r    <= 1'b0;
      s1_exp_r    <= {DW{1'b0}};
      s1_addr_r   <= {AW{1'b0}};
      s1_elem_r   <= 3'd0;
      s2_vld_r    <= 1'b0;
      s2_exp_r    <= {DW{1'b0}};
      s2_addr_r   <= {AW{1'b0}};
      s2_elem_r   <= 3'd0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_addr_o <= {AW{1'b0}};
      fail_elem_o <= 3'd0;
      fail_syn_o  <= {DW{1'b0}};
      fail_cnt_o  <= 16'd0;
      bist_en_o   <= 1'b0;
      bist_men_o  <= 1'b0;
      bist_wen_o  <= 1'b0;
      bist_ren_o  <= 1'b0;
      bist_addr_o <= {AW{1'b0}};
      bist_din_o  <= {DW{1'b0}};
      bist_bm_o   <= {DW{1'b0}};
    end else begin
      bist_men_o  <= 1'b0;
      bist_wen_o  <= 1'b0;
      bist_ren_o  <= 1'b0;
      bist_addr_o <= {AW{1'b0}};
      bist_din_o  <= {DW{1'b0}};
      bist_bm_o   <= {DW{1'b0}};
      s1_vld_r    <= 1'b0;
      s2_vld_r    <= s1_vld_r;
      s2_exp_r    <= s1_exp_r;
      s2_addr_r   <= s1_addr_r;
      s2_elem_r   <= s1_elem_r;
      fail_cnt_o  <= cnt_nx_s;
      if (mis_s && (fail_cnt_o == 16'd0)) begin
        fail_addr_o <= s2_addr_r;
        fail_elem_o <= s2_elem_r;
        fail_syn_o  <= syn_s;
      end
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_r     <= ST_RUN;
            busy_o      <= 1'b1;
            bist_en_o   <= 1'b1;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_addr_o <= {AW{1'b0}};
            fail_elem_o <= 3'd0;
            fail_syn_o  <= {DW{1'b0}};
            fail_cnt_o  <= 16'd0;
            s2_vld_r    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (last_s) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state_r   <= ST_DONE;
          busy_o    <= 1'b0;
          bist_en_o <= 1'b0;
          done_o    <= 1'b1;
          pass_o    <= (cnt_nx_s == 16'd0);
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_o    <= 1'b0;
          bist_en_o <= 1'b0;
        end
      endcase
      if (load_s) begin
        elem_r      <= ld_elem_s;
        addr_r      <= ld_addr_s;
        ph_r        <= ld_ph_s;
        bist_men_o  <= 1'b1;
        bist_wen_o  <= ~ld_rd_s;
        bist_ren_o  <= ld_rd_s;
        bist_addr_o <= ld_addr_s;
        bist_din_o  <= ld_rd_s ? {DW{1'b0}} : ld_pat_s;
        bist_bm_o   <= ld_rd_s ? {DW{1'b0}} : {DW{1'b1}};
        s1_vld_r    <= ld_rd_s;
        s1_exp_r    <= ld_pat_s;
        s1_addr_r   <= ld_addr_s;
        s1_elem_r   <= ld_elem_s;
      end
    end
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: behavioural 256x16 macro with injectable stuck-at bits,
// table-driven fault cases, random fault sets against a March C- reference model.
module tb_sram_march_bist;

  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int N    = 256;
  localparam int NACC = 10 * N;

  logic          clk_i = 1'b0;
  logic          rst_ni, start_i;
  logic          busy_o, done_o, pass_o;
  logic [AW-1:0] fail_addr_o;
  logic [2:0]    fail_elem_o;
  logic [DW-1:0] fail_syn_o;
  logic [15:0]   fail_cnt_o;
  logic          bist_en_o, bist_men_o, bist_wen_o, bist_ren_o;
  logic [AW-1:0] bist_addr_o;
  logic [DW-1:0] bist_din_o, bist_bm_o;
  logic [DW-1:0] dout_i = 16'h0000;
  logic [89:0]   all_outs_s;

  always #5 clk_i = ~clk_i;

  sram_march_bist #(.DW(DW), .AW(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .fail_addr_o(fail_addr_o), .fail_elem_o(fail_elem_o),
    .fail_syn_o(fail_syn_o), .fail_cnt_o(fail_cnt_o),
    .bist_en_o(bist_en_o), .bist_men_o(bist_men_o), .bist_wen_o(bist_wen_o),
    .bist_ren_o(bist_ren_o), .bist_addr_o(bist_addr_o), .bist_din_o(bist_din_o),
    .bist_bm_o(bist_bm_o), .dout_i(dout_i)
  );

  assign all_outs_s = {busy_o, done_o, pass_o, fail_addr_o, fail_elem_o, fail_syn_o,
                       fail_cnt_o, bist_en_o, bist_men_o, bist_wen_o, bist_ren_o,
                       bist_addr_o, bist_din_o, bist_bm_o};

  // Behavioural macro: masked write, registered read, stuck-at faults on the read path
  logic [DW-1:0] mem [N];
  logic [DW-1:0] sa1 [N];
  logic [DW-1:0] sa0 [N];

  always @(posedge clk_i) begin
    if (bist_men_o && bist_wen_o)
      mem[bist_addr_o] <= (mem[bist_addr_o] & ~bist_bm_o) | (bist_din_o & bist_bm_o);
    if (bist_men_o && bist_ren_o)
      dout_i <= (mem[bist_addr_o] | sa1[bist_addr_o]) & ~sa0[bist_addr_o];
  end

  // Reference access list of March C- in issue order
  logic          op_wr   [NACC];
  logic [AW-1:0] op_addr [NACC];
  logic          op_bit  [NACC];
  logic [2:0]    op_elem [NACC];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          fa;
    int          fb;
    bit          fv;
    bit          pass;
    logic [15:0] cnt;
    logic [7:0]  addr;
    logic [2:0]  elem;
    logic [15:0] syn;
  } vec_t;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // w0 ; r0,w1 ; r1,w0 ; down r0,w1 ; down r1,w0 ; r0
  task automatic build_ops();
    int k = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        int nops = (e == 0 || e == 5) ? 1 : 2;
        for (int j = 0; j < nops; j++) begin
          op_wr[k]   = (e == 0) || (j == 1);
          op_addr[k] = AW'((e == 3 || e == 4) ? (N - 1 - i) : i);
          op_bit[k]  = (e == 2 || e == 4) ? (j == 0) : ((e == 1 || e == 3) ? (j == 1) : 1'b0);
          op_elem[k] = 3'(e);
          k++;
        end
      end
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < N; a++) begin
      sa1[a] = 16'h0000;
      sa0[a] = 16'h0000;
    end
  endtask

  task automatic add_fault(input int a, input int b, input bit v);
    if (v) sa1[a][b] = 1'b1;
    else   sa0[a][b] = 1'b1;
  endtask

  task automatic ref_result(output bit pass, output logic [15:0] cnt, output logic [7:0] fa,
                            output logic [2:0] fe, output logic [15:0] fs);
    logic [DW-1:0] rm [N];
    logic [DW-1:0] val, exp;
    cnt = 16'd0; fa = 8'd0; fe = 3'd0; fs = 16'd0;
    for (int k = 0; k < NACC; k++) begin
      exp = {DW{op_bit[k]}};
      if (op_wr[k]) begin
        rm[op_addr[k]] = exp;
      end else begin
        val = (rm[op_addr[k]] | sa1[op_addr[k]]) & ~sa0[op_addr[k]];
        if (val != exp) begin
          if (cnt == 16'd0) begin
            fa = op_addr[k]; fe = op_elem[k]; fs = val ^ exp;
          end
          if (cnt != 16'hFFFF) cnt = cnt + 16'd1;
        end
      end
    end
    pass = (cnt == 16'd0);
  endtask

  task automatic run_march(input string tag, input int hold, input bit e_pass, input logic [15:0] e_cnt,
                           input logic [7:0] e_addr, input logic [2:0] e_elem, input logic [15:0] e_syn);
    int  done_edge = -1;
    int  busy_cyc  = 0;
    int  strb_err  = 0;
    bit  ok;
    logic wr;
    @(negedge clk_i);
    start_i = 1'b1;
    for (int e = 0; e < 3000 && done_edge < 0; e++) begin
      @(negedge clk_i);
      start_i = (e + 1 < hold);
      if (e == 0) begin
        check({tag, "_clr_done"}, done_o, 1'b0);
        check({tag, "_clr_cnt"}, {fail_cnt_o, fail_addr_o, fail_elem_o, fail_syn_o}, 43'd0);
      end
      if (busy_o) busy_cyc++;
      if (e < NACC) begin
        wr = op_wr[e];
        ok = bist_men_o && (bist_wen_o == wr) && (bist_ren_o == !wr) && (bist_addr_o == op_addr[e]) &&
             (bist_din_o == (wr ? {DW{op_bit[e]}} : 16'h0000)) &&
             (bist_bm_o == (wr ? 16'hFFFF : 16'h0000)) && bist_en_o && busy_o;
      end else if (e == NACC) begin
        ok = !bist_men_o && !bist_wen_o && !bist_ren_o && (bist_addr_o == 8'h00) &&
             (bist_din_o == 16'h0000) && (bist_bm_o == 16'h0000) && bist_en_o && busy_o;
      end else begin
        ok = 1'b1;
      end
      if (!ok) begin
        if (strb_err == 0)
          $display("  %s: first strobe deviation after edge %0d (men=%0b wen=%0b ren=%0b addr=%0h din=%0h bm=%0h)",
                   tag, e, bist_men_o, bist_wen_o, bist_ren_o, bist_addr_o, bist_din_o, bist_bm_o);
        strb_err++;
      end
      if (done_o) done_edge = e;
    end
    start_i = 1'b0;
    check({tag, "_done_edge"}, done_edge, NACC + 1);
    check({tag, "_busy_cycles"}, busy_cyc, NACC + 1);
    check({tag, "_strobe_errs"}, strb_err, 0);
    check({tag, "_idle_after"}, {busy_o, bist_en_o, bist_men_o}, 3'b000);
    check({tag, "_pass"}, pass_o, e_pass);
    check({tag, "_cnt"}, fail_cnt_o, e_cnt);
    check({tag, "_addr"}, fail_addr_o, e_addr);
    check({tag, "_elem"}, fail_elem_o, e_elem);
    check({tag, "_syn"}, fail_syn_o, e_syn);
  endtask

  initial begin
    vec_t vecs [5];
    bit          r_pass;
    logic [15:0] r_cnt, r_syn;
    logic [7:0]  r_addr;
    logic [2:0]  r_elem;

    vecs[0] = '{fa: -1,   fb: 0,  fv: 1'b0, pass: 1'b1, cnt: 16'd0, addr: 8'h00, elem: 3'd0, syn: 16'h0000};
    vecs[1] = '{fa: 8'h2A, fb: 3, fv: 1'b1, pass: 1'b0, cnt: 16'd3, addr: 8'h2A, elem: 3'd1, syn: 16'h0008};
    vecs[2] = '{fa: 8'hFF, fb: 15, fv: 1'b0, pass: 1'b0, cnt: 16'd2, addr: 8'hFF, elem: 3'd2, syn: 16'h8000};
    vecs[3] = '{fa: 8'h00, fb: 0, fv: 1'b0, pass: 1'b0, cnt: 16'd2, addr: 8'h00, elem: 3'd2, syn: 16'h0001};
    vecs[4] = '{fa: 8'hFF, fb: 15, fv: 1'b1, pass: 1'b0, cnt: 16'd3, addr: 8'hFF, elem: 3'd1, syn: 16'h8000};

    build_ops();
    clear_faults();
    rst_ni  = 1'b0;
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset_outs", all_outs_s, 90'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check("idle_outs", all_outs_s, 90'd0);

    for (int v = 0; v < 5; v++) begin
      clear_faults();
      if (vecs[v].fa >= 0) add_fault(vecs[v].fa, vecs[v].fb, vecs[v].fv);
      run_march($sformatf("vec%0d", v), 1, vecs[v].pass, vecs[v].cnt, vecs[v].addr,
                vecs[v].elem, vecs[v].syn);
    end

    // Random fault sets against the reference model, random idle gap before each start
    for (int t = 0; t < 6; t++) begin
      int nf = $urandom_range(0, 3);
      clear_faults();
      for (int f = 0; f < nf; f++)
        add_fault($urandom_range(0, N - 1), $urandom_range(0, DW - 1), 1'($urandom_range(0, 1)));
      ref_result(r_pass, r_cnt, r_addr, r_elem, r_syn);
      repeat ($urandom_range(0, 5)) @(negedge clk_i);
      run_march($sformatf("rnd%0d", t), 1, r_pass, r_cnt, r_addr, r_elem, r_syn);
    end

    // Start held high through RUN and DRAIN: exactly one run
    clear_faults();
    run_march("hold", NACC + 2, 1'b1, 16'd0, 8'h00, 3'd0, 16'h0000);
    repeat (4) @(negedge clk_i);
    check("hold_single_run", {done_o, busy_o, bist_men_o}, 3'b100);

    // Reset one cycle at edge 1000 of a run
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (999) @(negedge clk_i);
    check("midrst_busy_before", busy_o, 1'b1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("midrst_outs", all_outs_s, 90'd0);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    check("midrst_idle_outs", all_outs_s, 90'd0);
    run_march("post_rst", 1, 1'b1, 16'd0, 8'h00, 3'd0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_march_bist.md
# sram_march_bist

March C- built-in self-test controller for the single-port SRAM macros. It drives the macro's BIST port (enable, strobes, address, data, bit mask) and checks read data returned on the macro's data output. It runs a full March C- pass over every address, then reports pass/fail, the first failing address/element/syndrome and a saturating failure count. It sits directly upstream of one `RM_IHPSG13_1P_*_bm_bist` instance and is started by a test-controller register.

## Interface
- `DW`, 16, data / bit-mask width of the target macro.
- `AW`, 8, address width; depth N = 2**AW.
- `clk_i`  in  1  clock. Same net as the macro's BIST clock.
- `rst_ni`  in  1  reset: synchronous, active-low. One clock; reset is synchronous and active-low.
- `start_i`  in  1  start request. Sampled only in IDLE and DONE.
- `busy_o`  out  1  test in progress.
- `done_o`  out  1  test finished. Level signal, held until the next accepted start or reset.
- `pass_o`  out  1  no miscompare. Valid while `done_o`=1.
- `fail_addr_o`  out  AW  address of the first miscompare.
- `fail_elem_o`  out  3  March element (0..5) of the first miscompare.
- `fail_syn_o`  out  DW  `dout_i` XOR expected data at the first miscompare.
- `fail_cnt_o`  out  16  number of miscompared reads, saturating at 0xFFFF.
- `bist_en_o`  out  1  to the macro's BIST enable.
- `bist_men_o`, `bist_wen_o`, `bist_ren_o`  out  1 each  macro BIST strobes.
- `bist_addr_o`  out  AW  macro BIST address.
- `bist_din_o`  out  DW  macro BIST write data.
- `bist_bm_o`  out  DW  macro BIST bit mask.
- `dout_i`  in  DW  macro data output.

## Operation
- States:
  - IDLE: `start_i`=1 → RUN.
  - RUN: after the last access of element 5 → DRAIN.
  - DRAIN: → DONE after one cycle.
  - DONE: `start_i`=1 → RUN.
- Accepting a start clears `done_o`, `pass_o`, `fail_*_o` and `fail_cnt_o`. It loads element 0 and address 0.
- `start_i` is ignored in RUN and DRAIN.
- March elements, with D0 = all zeros and D1 = all ones (DW bits):
  - E0: ascending, w0.
  - E1: ascending, r0 then w1.
  - E2: ascending, r1 then w0.
  - E3: descending (N-1 down to 0), r0 then w1.
  - E4: descending, r1 then w0.
  - E5: ascending, r0.
- E0 and E5 take one access per address. E1–E4 take a read then a write at the same address on consecutive cycles.
- Total accesses: 10·N. They are issued back to back with no idle cycles, including across element boundaries.
- Address counter wraps at element boundaries: to 0 for ascending elements, to N-1 for descending ones.
- Access encoding:
  - Write: `men`=1, `wen`=1, `ren`=0, `din` = pattern, `bm` = all ones.
  - Read: `men`=1, `ren`=1, `wen`=0, `din` = 0, `bm` = 0.
- Outside RUN: `men`/`wen`/`ren`=0, `din`/`bm`/`addr`=0.
- `bist_en_o` = 1 in RUN and DRAIN.
- Each read carries its expected data, address and element through a two-stage pipeline.
- On a miscompare:
  - `fail_cnt_o` increments, saturating at 0xFFFF.
  - If this is the first miscompare, `fail_addr_o`, `fail_elem_o` and `fail_syn_o` are captured.
- The test never aborts early.
- `pass_o` = (`fail_cnt_o` == 0) when entering DONE.

## Timing
- All outputs are registered.
- Reset values: every output 0, state IDLE.
- A reset mid-test returns all outputs to 0 at that edge. The macro sees no further strobes.
- Call the edge that accepts `start_i` edge 0.
  - Access k (k = 0..10N-1) is driven on `bist_*` during the cycle after edge k.
  - The macro samples access k at edge k+1.
- Read launched at edge k: `dout_i` is checked, and result state is updated, at edge k+2.
- `busy_o` rises at edge 0.
- At edge 10N+1: `busy_o` falls, and `done_o` and `pass_o` are valid. This includes the compare of the final E5 read.
- N=256: `done_o` rises 2561 cycles after start.
- A restart from DONE is accepted at any edge. The next run's edge 0 is that edge.

## Test plan
- Fault-free 256x16 behavioural macro, pulse `start_i` → `busy_o` for 2561 cycles, then `done_o`=1, `pass_o`=1, `fail_cnt_o`=0.
- Stuck-at-1 on bit 3 at address 0x2A → `pass_o`=0, `fail_addr_o`=0x2A, `fail_elem_o`=1, `fail_syn_o`=0x0008, `fail_cnt_o`=3 (E1, E3, E5).
- Stuck-at-0 on bit 15 at address 0xFF → `fail_elem_o`=2, `fail_syn_o`=0x8000, `fail_cnt_o`=2.
- Monitor strobes → exactly 10·256 `men` cycles with no gaps. E3's first address is 0xFF and its last is 0x00. `bm`=0xFFFF on writes only.
- `start_i` held high through RUN, then deasserted → a single run only; `done_o` at cycle 2561.
- Assert `rst_ni`=0 at cycle 1000 for one cycle → all outputs 0 at the next edge, state IDLE. A following start gives a clean pass in 2561 cycles.
